// File: rtl/pwm_pkg.sv
// Purpose: shared constants, types and the PWM compare helper for the PWM peripheral.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pwm_pkg;

  // Default prescale ratio: clk cycles per PWM tick.
  localparam int unsigned CLK_DIV_DEF = 13;

  // PWM counter width and the duty value that means "always high".
  localparam int unsigned     PWM_W     = 8;
  localparam logic [PWM_W-1:0] DUTY_FULL = 8'hFF;

  typedef logic [PWM_W-1:0] pwm_cnt_t;

  // Duty 255 must be a true 100 %: a plain cnt < duty compare would drop the
  // pwm_cnt == 255 slot and leave one low tick per period.
  function automatic logic pwm_level(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Purpose: free-running prescaler plus 8-bit PWM counter, with period-start pulse.
// Latency: period_start is registered, high for one clk after pwm_cnt wraps 255 -> 0.
// Backpressure: none; counters free-run and never stall.
// Ports: clk, rst_n (async active-low); pwm_cnt (current count), wrap (comb,
//        high on the tick that takes pwm_cnt 255 -> 0), period_start (registered pulse).
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  output pwm_cnt_t pwm_cnt,
  output logic     wrap,
  output logic     period_start
);

  localparam logic [7:0] PRE_MAX = 8'(CLK_DIV - 1);

  logic [7:0] pre_cnt_q, pre_cnt_d;
  pwm_cnt_t   pwm_cnt_q, pwm_cnt_d;
  logic       period_start_q, period_start_d;
  logic       tick;

  always_comb begin
    tick           = (pre_cnt_q == PRE_MAX);
    pre_cnt_d      = tick ? 8'd0 : pre_cnt_q + 8'd1;
    pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    wrap           = tick && (pwm_cnt_q == DUTY_FULL);
    period_start_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q      <= 8'd0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= period_start_d;
    end
  end

  assign pwm_cnt      = pwm_cnt_q;
  assign period_start = period_start_q;

endmodule

// File: rtl/pwm_peripheral.sv
// Purpose: 16-channel PWM/static output block sharing one timebase and one duty value.
// Latency: out is registered, one clk after the count/enable/duty values that produce it.
// Backpressure: none; enables and duty are level inputs sampled every clk.
// Ports: clk, rst_n (async active-low); en_reg_out_*/en_reg_pwm_* per-bit enable and
//        PWM-mode select; pwm_duty_cycle (0 = 0 %, 255 = 100 %); out[15:0]; period_start.
// Option: define PWM_SYNC_UPDATE_EN to latch the duty into a shadow register at each
//         period wrap (glitch-free, period-aligned); otherwise duty is used directly.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  pwm_cnt_t    pwm_cnt;
  logic        wrap;
  pwm_cnt_t    duty_eff;
  logic        pwm_sig;
  logic [15:0] en_out, en_pwm;
  logic [15:0] out_q, out_d;

  pwm_timebase #(
    .CLK_DIV      (CLK_DIV)
  ) u_timebase (
    .clk          (clk),
    .rst_n        (rst_n),
    .pwm_cnt      (pwm_cnt),
    .wrap         (wrap),
    .period_start (period_start)
  );

`ifdef PWM_SYNC_UPDATE_EN
  pwm_cnt_t duty_shadow_q, duty_shadow_d;

  // Load only on the wrap tick so a duty write never cuts a period short.
  always_comb begin
    duty_shadow_d = wrap ? pwm_duty_cycle : duty_shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow_q <= '0;
    end else begin
      duty_shadow_q <= duty_shadow_d;
    end
  end

  assign duty_eff = duty_shadow_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
  assign duty_eff    = pwm_duty_cycle;
`endif

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Per bit: off -> 0, static mode -> 1, PWM mode -> shared pwm_sig.
  always_comb begin
    pwm_sig = pwm_level(pwm_cnt, duty_eff);
    out_d   = en_out & (~en_pwm | {16{pwm_sig}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 16'h0000;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule
